// File: rtl/multicycle_maindec.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_maindec
//  Purpose  : Main control FSM for the multicycle LEGv8 datapath. Steps each
//             instruction through fetch/decode/execute/memory/writeback,
//             with memory wait states, a mem_ready handshake and illegal
//             opcode trapping.
//  Options  : define UNCOND_BRANCH_EN to decode 000101????? as unconditional
//             branch (state B); otherwise that opcode traps as illegal.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_maindec #(
  parameter int MEM_WAIT    = 0,   // extra cycles per memory state (0..15)
  parameter int TRAP_STICKY = 1    // 1: TRAP holds until reset, 0: retire as NOP
) (
  input  logic        clk,
  input  logic        reset,       // synchronous, active-low
  input  logic [10:0] op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        illegal,
  output logic        instr_retired,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_CBZ    = 4'd8,
    S_B      = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  localparam logic [3:0]  c_MEM_WAIT = 4'(MEM_WAIT);
  localparam logic [10:0] c_OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] c_OP_STUR  = 11'b11111000000;
  localparam logic [10:0] c_OP_CBZ   = 11'b10110100000;

  state_t     r_state;
  logic [3:0] r_count;
  state_t     w_decode_next;
  logic       w_mem_state;
  logic       w_done;
  logic       w_r2l_decode;

  // Wait counter only runs in the three memory-access states. It saturates
  // at MEM_WAIT so that a slow mem_ready can never push it past the match.
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                       (r_state == S_MEMWR);
  assign w_done      = (r_count == c_MEM_WAIT) && mem_ready;

  // Stores and CBZ read Rt on the second register port during decode.
  assign w_r2l_decode = (op == c_OP_STUR) || (op[10:3] == c_OP_CBZ[10:3]);

  assign state_o = r_state;

  // Opcode decode selects the first execution state after DECODE.
  always_comb begin
    w_decode_next = S_TRAP;
    casez (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: w_decode_next = S_EXEC;
      11'b11111000010,
      11'b11111000000: w_decode_next = S_MEMADR;
      11'b10110100???: w_decode_next = S_CBZ;
`ifdef UNCOND_BRANCH_EN
      11'b000101?????: w_decode_next = S_B;
`endif
      default:         w_decode_next = S_TRAP;
    endcase
  end

  // State register and wait counter; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      if (w_mem_state && !w_done) begin
        if (r_count != c_MEM_WAIT) r_count <= r_count + 4'd1;
      end else begin
        r_count <= '0;
      end

      case (r_state)
        S_FETCH:  if (w_done) r_state <= S_DECODE;
        S_DECODE: r_state <= w_decode_next;
        S_MEMADR: r_state <= (op == c_OP_LDUR) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (w_done) r_state <= S_MEMWB;
        S_MEMWR:  if (w_done) r_state <= S_FETCH;
        S_EXEC:   r_state <= S_ALUWB;
        S_MEMWB,
        S_ALUWB,
        S_CBZ,
        S_B:      r_state <= S_FETCH;
        S_TRAP:   if (TRAP_STICKY == 0) r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Moore decode of the state register; enables also gated by reset.
  always_comb begin
    Reg2Loc       = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    PCWrite       = 1'b0;
    PCSrc         = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    illegal       = 1'b0;
    instr_retired = 1'b0;

    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = w_done;
        PCWrite = w_done;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Reg2Loc = w_r2l_decode;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        Reg2Loc = 1'b1;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite      = 1'b1;
        MemtoReg      = 1'b1;
        instr_retired = 1'b1;
      end
      S_MEMWR: begin
        IorD          = 1'b1;
        MemWrite      = 1'b1;
        Reg2Loc       = 1'b1;
        instr_retired = w_done;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite      = 1'b1;
        instr_retired = 1'b1;
      end
      S_CBZ: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        Reg2Loc       = 1'b1;
        PCSrc         = 1'b1;
        PCWrite       = zero;
        instr_retired = 1'b1;
      end
`ifdef UNCOND_BRANCH_EN
      S_B: begin
        PCSrc         = 1'b1;
        PCWrite       = 1'b1;
        instr_retired = 1'b1;
      end
`endif
      S_TRAP: begin
        illegal       = 1'b1;
        instr_retired = (TRAP_STICKY == 0);
      end
      default: ;
    endcase

    if (!reset) begin
      PCWrite       = 1'b0;
      IRWrite       = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      illegal       = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_maindec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_maindec
//  Purpose  : Self-checking bench for multicycle_maindec with an
//             instruction-level reference model (phase lists per opcode
//             class, phase lengths from MEM_WAIT and mem_ready).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_maindec;

  localparam int P_MEM_WAIT = 2;
  localparam int P_STICKY   = 1;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  // Output vector bit positions of the enables that reset must force low.
  localparam logic [15:0] c_EN_MASK = 16'h01E7;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] op;
  logic        zero;
  logic        mem_ready;
  logic        Reg2Loc, ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic        PCSrc, MemtoReg, RegWrite, illegal, instr_retired;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state_o;
  logic [15:0] w_obs;

  int n_checks = 0;
  int n_pass   = 0;

  multicycle_maindec #(.MEM_WAIT(P_MEM_WAIT), .TRAP_STICKY(P_STICKY)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .illegal(illegal), .instr_retired(instr_retired),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  assign w_obs = {Reg2Loc, ALUSrcA, ALUSrcB, ALUOp, IorD, MemRead, MemWrite,
                  IRWrite, PCWrite, PCSrc, MemtoReg, RegWrite, illegal,
                  instr_retired};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic int classify(input logic [10:0] o);
    if (o == 11'b10001011000 || o == 11'b11001011000 ||
        o == 11'b10001010000 || o == 11'b10101010000) return C_R;
    if (o == 11'b11111000010) return C_LD;
    if (o == 11'b11111000000) return C_ST;
    if (o[10:3] == 8'b10110100) return C_CBZ;
`ifdef UNCOND_BRANCH_EN
    if (o[10:5] == 6'b000101) return C_B;
`endif
    return C_ILL;
  endfunction

  function automatic bit is_mem(input int st);
    return (st == 0) || (st == 3) || (st == 5);
  endfunction

  // Expected control outputs for one cycle, straight from the state table.
  function automatic logic [15:0] exp_out(input int st, input int cls, input bit done, input bit z);
    logic r2l, asa, iord, mr, mw, irw, pcw, pcs, m2r, rw, ill, ret;
    logic [1:0] asb, aop;
    {r2l, asa, iord, mr, mw, irw, pcw, pcs, m2r, rw, ill, ret} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (st)
      0:  begin mr = 1; asb = 2'b01; irw = done; pcw = done; end
      1:  begin asb = 2'b11; r2l = (cls == C_ST) || (cls == C_CBZ); end
      2:  begin asa = 1; asb = 2'b10; r2l = 1; end
      3:  begin iord = 1; mr = 1; end
      4:  begin rw = 1; m2r = 1; ret = 1; end
      5:  begin iord = 1; mw = 1; r2l = 1; ret = done; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; ret = 1; end
      8:  begin asa = 1; aop = 2'b01; r2l = 1; pcs = 1; pcw = z; ret = 1; end
      9:  begin pcs = 1; pcw = 1; ret = 1; end
      10: begin ill = 1; ret = (P_STICKY == 0); end
      default: ;
    endcase
    return {r2l, asa, asb, aop, iord, mr, mw, irw, pcw, pcs, m2r, rw, ill, ret};
  endfunction

  // Run one instruction from FETCH. extra<0: random mem_ready; otherwise
  // mem_ready is high during the mandatory wait (must be ignored) and then
  // low for 'extra' cycles in MEMRD/MEMWR. If abort_st is reached and has
  // lasted abort_k cycles, reset is pulsed there instead.
  task automatic run_instr(input logic [10:0] op_v, input logic z_v, input int extra,
                           input int abort_st, input int abort_k);
    int  cls;
    int  seq[$];
    int  retired;
    bit  stop;
    retired = 0;
    stop    = 0;
    op      = op_v;
    zero    = z_v;
    cls     = classify(op_v);
    case (cls)
      C_R:     seq = '{0, 1, 6, 7};
      C_LD:    seq = '{0, 1, 2, 3, 4};
      C_ST:    seq = '{0, 1, 2, 5};
      C_CBZ:   seq = '{0, 1, 8};
      C_B:     seq = '{0, 1, 9};
      default: seq = '{0, 1, 10};
    endcase
    foreach (seq[i]) begin
      int st;
      int k;
      bit done_m;
      st = seq[i];
      k  = 0;
      forever begin
        if (extra < 0)            mem_ready = 1'($urandom_range(0, 1));
        else if (k < P_MEM_WAIT)  mem_ready = 1'b1;
        else if (st == 0)         mem_ready = 1'b1;
        else                      mem_ready = (k >= P_MEM_WAIT + extra);
        if (st == abort_st && k == abort_k) begin
          reset = 1'b0;
          @(negedge clk);
          chk("rst_state", 16'(state_o), 16'(st));
          chk("rst_outs", w_obs, exp_out(st, cls, 1'b0, z_v) & ~c_EN_MASK);
          @(posedge clk); #1;
          chk("rst_to_fetch", 16'(state_o), 16'd0);
          reset = 1'b1;
          stop  = 1;
          break;
        end
        @(negedge clk);
        done_m = is_mem(st) ? (k >= P_MEM_WAIT && mem_ready)
                            : !(st == 10 && P_STICKY != 0);
        chk("state", 16'(state_o), 16'(st));
        chk("outs", w_obs, exp_out(st, cls, done_m, z_v));
        retired += int'(instr_retired);
        @(posedge clk); #1;
        k++;
        if (done_m) break;
        if (k > 60) begin
          n_checks++;
          $error("FAIL timeout state=%0d cycles=%0d expected exit", st, k);
          stop = 1;
          break;
        end
      end
      if (stop) break;
    end
    if (!stop) chk("retired", 16'(retired), 16'd1);
  endtask

  logic [10:0] r_ops [4] = '{11'b10001011000, 11'b11001011000,
                             11'b10001010000, 11'b10101010000};

  initial begin
    logic [10:0] o;
    int c;
    reset     = 1'b0;
    op        = '0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", 16'(state_o), 16'd0);
    chk("reset_outs", w_obs, exp_out(0, C_R, 1'b0, 1'b0) & ~c_EN_MASK);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed instruction sequence.
    run_instr(11'b10001011000, 1'b0, 0, -1, 0);   // ADD
    run_instr(11'b11111000010, 1'b0, 1, -1, 0);   // LDUR, one slow MEMRD cycle
    run_instr(11'b10110100101, 1'b1, 0, -1, 0);   // CBZ taken
    run_instr(11'b10110100101, 1'b0, 0, -1, 0);   // CBZ not taken
    run_instr(11'b11111111111, 1'b0, 0, 10, 20);  // sticky trap, then reset
    run_instr(11'b11111000000, 1'b0, 100, 5, 3);  // STUR, reset mid-MEMWR
    run_instr(11'b10001011000, 1'b0, 0, -1, 0);   // counter must restart at 0
`ifdef UNCOND_BRANCH_EN
    run_instr(11'b00010100000, 1'b0, 0, -1, 0);
`else
    run_instr(11'b00010100000, 1'b0, 0, 10, 2);
`endif

    // Randomized instruction mix with random mem_ready.
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 5);
      case (c)
        0:       o = r_ops[$urandom_range(0, 3)];
        1:       o = 11'b11111000010;
        2:       o = 11'b11111000000;
        3:       o = {8'b10110100, 3'($urandom)};
        4:       o = {6'b000101, 5'($urandom)};
        default: begin
          o = 11'($urandom);
          while (classify(o) != C_ILL) o = 11'($urandom);
        end
      endcase
      if (classify(o) == C_ILL && P_STICKY != 0)
        run_instr(o, 1'($urandom), -1, 10, $urandom_range(0, 4));
      else
        run_instr(o, 1'($urandom), -1, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_maindec.md
Name: multicycle_maindec

Overview:
- Main control FSM for the multicycle LEGv8 datapath. Successor to the single-cycle combinational main decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Supports a parametrised memory wait-state count, a mem_ready handshake, illegal-opcode trapping and an optional unconditional branch.
- Drives the shared ALU, memory, IR and PC enables of the multicycle datapath.

Parameters:
- MEM_WAIT, 0, minimum extra cycles spent in each memory-access state before mem_ready is sampled (0..15).
- TRAP_STICKY, 1. When 1, an illegal opcode parks the FSM in TRAP until reset. When 0, an illegal opcode flags illegal for one cycle and is retired as a NOP.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- op  in  11  instruction bits [31:21] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- Reg2Loc  out  1  register read port 2 selects Rt (1) or Rm (0)
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUOp  out  2  00 = add, 01 = pass-B/compare, 10 = funct-decoded
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1  memory strobes
- IRWrite  out  1  load IR
- PCWrite  out  1  load PC
- PCSrc  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target)
- MemtoReg  out  1  writeback source: 0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- illegal  out  1  unknown opcode decoded
- instr_retired  out  1  one-cycle pulse in the last cycle of every instruction
- state_o  out  4  current state encoding, for debug

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, CBZ=8, B=9, TRAP=10.
  - Outputs are Moore decodes of the state register, except the completion-qualified enables noted below. Unlisted outputs are 0.
- Reset:
  - reset=0 at any clock edge forces state=FETCH and wait counter=0, regardless of the current state.
  - While reset=0, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, illegal and instr_retired are forced to 0.
- Wait counter:
  - Applies to FETCH, MEMRD and MEMWR. The counter increments each cycle in the state and clears on exit.
  - done = (count==MEM_WAIT) && mem_ready.
  - The FSM holds the state while done=0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00. IRWrite=PCWrite=done. Next state DECODE when done.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Reg2Loc=1 if op is STUR or CBZ.
  - Next state by op:
    - 10001011000, 11001011000, 10001010000, 10101010000 -> EXEC
    - 11111000010 (LDUR) or 11111000000 (STUR) -> MEMADR
    - 10110100??? -> CBZ
    - 000101????? -> B (macro only)
    - anything else -> TRAP
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=1. Next MEMRD for LDUR, MEMWR for STUR.
- MEMRD: IorD=1, MemRead=1. Next MEMWB on done.
- MEMWB: RegWrite=1, MemtoReg=1, instr_retired=1. Next FETCH.
- MEMWR: IorD=1, MemWrite=1 (held for the whole state), Reg2Loc=1. instr_retired=done. Next FETCH on done.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: RegWrite=1, MemtoReg=0, instr_retired=1. Next FETCH.
- CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCSrc=1, PCWrite=zero, instr_retired=1. Next FETCH.
- TRAP:
  - illegal=1.
  - TRAP_STICKY=1: stays in TRAP until reset. All enables remain 0.
  - TRAP_STICKY=0: instr_retired=1, next FETCH.
- Latency, MEM_WAIT=0 and mem_ready tied 1:
  - R-type 4 cycles, LDUR 5, STUR 4, CBZ 3, B 3.
  - Each memory state adds MEM_WAIT cycles plus any cycles with mem_ready low.
- mem_ready high before count reaches MEM_WAIT is ignored.

Optional Feature:
- Macro: UNCOND_BRANCH_EN.
- Defined: DECODE maps 000101????? to state B. In B: PCSrc=1, PCWrite=1, instr_retired=1. Next FETCH.
- Undefined: 000101????? is illegal and goes to TRAP. State code 9 is unreachable.

Test Plan:
- ADD (op=10001011000), MEM_WAIT=0, mem_ready=1 -> state sequence 0,1,6,7,0. RegWrite=1 only in state 7. instr_retired pulses once.
- LDUR with MEM_WAIT=2 and mem_ready low for 1 extra cycle in MEMRD -> FETCH lasts 3 cycles, MEMRD lasts 4 cycles. MemRead held throughout. RegWrite=1, MemtoReg=1 in MEMWB.
- CBZ (op=10110100101) run twice, once with zero=1 and once with zero=0 -> PCWrite=1 and PCWrite=0 respectively in state 8. PCSrc=1 in both. Return to FETCH.
- op=11111111111 with TRAP_STICKY=1 -> state 10, illegal=1, held for 20 cycles. Then reset=0 for 1 cycle -> state 0.
- STUR in MEMWR, reset=0 asserted mid-state -> MemWrite=0 in that same cycle. Next edge state=0, counter=0.
- op=00010100000 -> with UNCOND_BRANCH_EN: states 0,1,9,0, PCWrite=1 in state 9. Without the macro: state 10, illegal=1.
